// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and baud divider math.
package uart_rx_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    function automatic logic [CNT_W-1:0] calc_baud_div(input int unsigned clk_freq,
                                                       input int unsigned baud_rate);
        return CNT_W'(clk_freq / baud_rate);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-facing bundle: serial line in, byte/status strobes out.
// data_valid and frame_err are single-cycle strobes with no backpressure; data_out holds until the next good byte.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    modport master (output rx, input data_out, input data_valid, input frame_err, input busy);
    modport slave  (input rx, output data_out, output data_valid, output frame_err, output busy);
endinterface

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a selectable reset level.
module uart_rx_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge detection, mid-bit sampling, one-cycle valid / framing-error strobes.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic        clk,
    input  logic        rst_n,
    uart_rx_if.slave    s_bus,
    output uart_state_t o_state
);
    localparam logic [CNT_W-1:0] BAUD_DIV  = calc_baud_div(CLK_FREQ, BAUD_RATE);
    localparam logic [CNT_W-1:0] HALF_DIV  = BAUD_DIV >> 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = BAUD_DIV - CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_LAST = HALF_DIV - CNT_W'(1);

    logic             w_rx_s;
    logic             w_fall;
    logic             w_half_done;
    logic             w_bit_done;

    uart_state_t      r_state;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data_out;
    logic             r_valid;
    logic             r_ferr;
    logic             r_busy;
    logic             r_rx_prev;
    logic [1:0]       r_settle;

    uart_rx_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (s_bus.rx),
        .o_q   (w_rx_s)
    );

    // Edges are ignored until the synchronizer and history flop hold real line values,
    // so a line still low when reset releases cannot start a frame.
    assign w_fall      = (r_settle == 2'd3) && r_rx_prev && !w_rx_s;
    assign w_half_done = (r_baud_cnt == HALF_LAST);
    assign w_bit_done  = (r_baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
            r_busy     <= 1'b0;
            r_rx_prev  <= 1'b1;
            r_settle   <= '0;
        end else begin
            r_rx_prev <= w_rx_s;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;

            case (r_state)
                IDLE: begin
                    r_baud_cnt <= '0;
                    if (w_fall) begin
                        r_state <= START;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (w_half_done) begin
                        r_baud_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (w_bit_done) begin
                        r_baud_cnt         <= '0;
                        r_shift[r_bit_idx] <= w_rx_s;
                        if (r_bit_idx == 3'd7) r_state <= STOP;
                        else                   r_bit_idx <= r_bit_idx + 3'd1;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
                    if (w_bit_done) begin
                        r_baud_cnt <= '0;
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        if (w_rx_s) begin
                            r_data_out <= r_shift;
                            r_valid    <= 1'b1;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_baud_cnt <= '0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign s_bus.data_out   = r_data_out;
    assign s_bus.data_valid = r_valid;
    assign s_bus.frame_err  = r_ferr;
    assign s_bus.busy       = r_busy;
    assign o_state          = r_state;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial driver tasks, expected-byte queue scoreboard, summary report.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int unsigned BAUD_RATE = 115200;
    localparam int unsigned CLK_FREQ  = BAUD_RATE * 16;
    localparam int BAUD_DIV  = 16;
    localparam int HALF_DIV  = 8;
    localparam int CLK_HALF  = 50;
    localparam int BIT_T     = 1600;
    localparam int BIT_FAST  = 1568;
    localparam int BIT_SLOW  = 1632;
    localparam int EXP_LAT   = 2 + HALF_DIV + 9 * BAUD_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    uart_state_t dbg_state;
    uart_rx_if   bus();

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_bus   (bus),
        .o_state (dbg_state)
    );

    always #CLK_HALF clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] exp_q[$];
    int  n_valid = 0;
    int  n_ferr = 0;
    int  cyc = 0;
    int  valid_cyc = 0;
    bit  busy_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every valid strobe must match the oldest expected byte.
    always @(negedge clk) begin
        if (bus.data_valid && bus.frame_err) check("valid_ferr_exclusive", 32'd1, 32'd0);
        if (bus.data_valid) begin
            n_valid++;
            valid_cyc = cyc;
            if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
            else                   check("rx_byte", 32'(bus.data_out), 32'(exp_q.pop_front()));
        end
        if (bus.frame_err) n_ferr++;
        if (bus.busy) busy_seen = 1'b1;
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int bit_t);
        bus.rx = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            #(bit_t);
        end
        bus.rx = stop_v;
        #(bit_t);
    endtask

    task automatic send_byte(input logic [7:0] b, input int bit_t);
        exp_q.push_back(b);
        send_frame(b, 1'b1, bit_t);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data_out"}, 32'(bus.data_out), 32'd0);
        check({tag, "_valid"}, 32'(bus.data_valid), 32'd0);
        check({tag, "_ferr"}, 32'(bus.frame_err), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        #(200_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    int t0;
    int lat;
    int v0;
    int f0;

    initial begin
        bus.rx = 1'b1;
        rst_n  = 1'b0;
        idle(3);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        idle(5);

        // Single byte with latency measurement from the start edge.
        v0 = n_valid; f0 = n_ferr;
        t0 = cyc;
        send_byte(8'h55, BIT_T);
        idle(4);
        lat = valid_cyc - t0;
        check("t1_valid_count", 32'(n_valid - v0), 32'd1);
        check("t1_no_ferr", 32'(n_ferr - f0), 32'd0);
        check("t1_data_out", 32'(bus.data_out), 32'h55);
        check("t1_latency_window", 32'((lat >= EXP_LAT - 2) && (lat <= EXP_LAT + 2)), 32'd1);

        // Back-to-back frames with no idle gap.
        v0 = n_valid; f0 = n_ferr;
        send_byte(8'hA3, BIT_T);
        send_byte(8'h00, BIT_T);
        send_byte(8'hFF, BIT_T);
        idle(4);
        check("t2_valid_count", 32'(n_valid - v0), 32'd3);
        check("t2_no_ferr", 32'(n_ferr - f0), 32'd0);
        check("t2_data_out", 32'(bus.data_out), 32'hFF);
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // Short low glitch: false start, then a real byte.
        v0 = n_valid; f0 = n_ferr;
        busy_seen = 1'b0;
        bus.rx = 1'b0;
        idle(4);
        bus.rx = 1'b1;
        idle(2 * BAUD_DIV);
        check("t3_busy_seen", 32'(busy_seen), 32'd1);
        check("t3_busy_low", 32'(bus.busy), 32'd0);
        check("t3_no_valid", 32'(n_valid - v0), 32'd0);
        check("t3_no_ferr", 32'(n_ferr - f0), 32'd0);
        send_byte(8'h3C, BIT_T);
        idle(4);
        check("t3_valid_count", 32'(n_valid - v0), 32'd1);
        check("t3_data_out", 32'(bus.data_out), 32'h3C);

        // Bad stop bit followed by a break, then recovery.
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h81, 1'b0, BIT_T);
        idle(4);
        check("t4_ferr_once", 32'(n_ferr - f0), 32'd1);
        check("t4_no_valid", 32'(n_valid - v0), 32'd0);
        check("t4_data_held", 32'(bus.data_out), 32'h3C);
        #(20 * BIT_T);
        check("t4_break_single_ferr", 32'(n_ferr - f0), 32'd1);
        check("t4_break_idle", 32'(bus.busy), 32'd0);
        bus.rx = 1'b1;
        idle(2 * BAUD_DIV);
        send_byte(8'h42, BIT_T);
        idle(4);
        check("t4_recover_valid", 32'(n_valid - v0), 32'd1);
        check("t4_recover_data", 32'(bus.data_out), 32'h42);
        check("t4_recover_ferr", 32'(n_ferr - f0), 32'd1);

        // Reset in the middle of data bit 4.
        fork
            send_frame(8'hF0, 1'b1, BIT_T);
            begin
                #(5 * BIT_T + BIT_T / 2);
                rst_n = 1'b0;
                #1;
                check_outputs_zero("t5_mid_reset");
                idle(2);
                rst_n = 1'b1;
            end
        join
        v0 = n_valid; f0 = n_ferr;
        idle(2 * BAUD_DIV);
        check("t5_no_spurious_valid", 32'(n_valid - v0), 32'd0);
        check("t5_no_spurious_ferr", 32'(n_ferr - f0), 32'd0);
        send_byte(8'h5A, BIT_T);
        idle(4);
        check("t5_valid_count", 32'(n_valid - v0), 32'd1);
        check("t5_data_out", 32'(bus.data_out), 32'h5A);
        check("t5_no_ferr", 32'(n_ferr - f0), 32'd0);

        // Full byte sweep with the transmitter 2% fast, then 2% slow.
        v0 = n_valid; f0 = n_ferr;
        for (int i = 0; i < 128; i++) send_byte(8'(i), BIT_FAST);
        for (int i = 128; i < 256; i++) send_byte(8'(i), BIT_SLOW);
        idle(4);
        check("t6_valid_count", 32'(n_valid - v0), 32'd256);
        check("t6_no_ferr", 32'(n_ferr - f0), 32'd0);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
